// File: rtl/axi_req_executor.sv
// Runs one 72-bit register request at a time as an AXI4-Lite master transaction
// and reports status/read data on a 40-bit response stream.
module axi_req_executor #(
  parameter int ADDR_WIDTH     = 32,
  parameter bit EMIT_WRITE_RSP = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetn,
  // Handshakes: a beat transfers on the rising edge where VALID and READY are both high;
  // a VALID, once raised, holds with stable payload until that edge.
  input  logic [71:0]           REQ_TDATA,
  input  logic                  REQ_TVALID,
  output logic                  REQ_TREADY,
  output logic [39:0]           RSP_TDATA,
  output logic                  RSP_TVALID,
  input  logic                  RSP_TREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [31:0]           M_AXI_WDATA,
  output logic [3:0]            M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  input  logic [31:0]           M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY,
  output logic [31:0]           write_count,
  output logic [31:0]           read_count,
  output logic [31:0]           error_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RRESP = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign dbg_state    = state;

  // A channel counts as done once its VALID is low or completes this cycle.
  always_comb begin
    aw_done = !M_AXI_AWVALID || M_AXI_AWREADY;
    w_done  = !M_AXI_WVALID  || M_AXI_WREADY;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      REQ_TREADY    <= 1'b0;
      RSP_TDATA     <= 40'h0;
      RSP_TVALID    <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= 32'h0;
      M_AXI_WSTRB   <= 4'h0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      write_count   <= 32'h0;
      read_count    <= 32'h0;
      error_count   <= 32'h0;
    end else begin
      M_AXI_WSTRB <= 4'hF;
      case (state)
        IDLE: begin
          REQ_TREADY <= 1'b1;
          if (REQ_TVALID && REQ_TREADY) begin
            REQ_TREADY <= 1'b0;
            case (REQ_TDATA[71:64])
              8'd0: begin
                state         <= WADDR;
                M_AXI_AWADDR  <= REQ_TDATA[32 +: ADDR_WIDTH];
                M_AXI_WDATA   <= REQ_TDATA[31:0];
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
              end
              8'd1: begin
                state         <= RADDR;
                M_AXI_ARADDR  <= REQ_TDATA[32 +: ADDR_WIDTH];
                M_AXI_ARVALID <= 1'b1;
              end
              default: begin
                // Unknown opcode: answered locally with SLVERR, never reaches the bus.
                state      <= RSP;
                RSP_TVALID <= 1'b1;
                RSP_TDATA  <= {5'b0, 1'b0, 2'b10, 32'h0};
                if (error_count != 32'hFFFF_FFFF) error_count <= error_count + 32'd1;
              end
            endcase
          end
        end
        WADDR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if (aw_done && w_done) begin
            state        <= WRESP;
            M_AXI_BREADY <= 1'b1;
          end
        end
        WRESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            write_count  <= write_count + 32'd1;
            if (M_AXI_BRESP != 2'b00 && error_count != 32'hFFFF_FFFF)
              error_count <= error_count + 32'd1;
            if (EMIT_WRITE_RSP || M_AXI_BRESP != 2'b00) begin
              state      <= RSP;
              RSP_TVALID <= 1'b1;
              RSP_TDATA  <= {5'b0, 1'b0, M_AXI_BRESP, 32'h0};
            end else begin
              state      <= IDLE;
              REQ_TREADY <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (M_AXI_ARREADY) begin
            state         <= RRESP;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
          end
        end
        RRESP: begin
          if (M_AXI_RVALID) begin
            state        <= RSP;
            M_AXI_RREADY <= 1'b0;
            read_count   <= read_count + 32'd1;
            if (M_AXI_RRESP != 2'b00 && error_count != 32'hFFFF_FFFF)
              error_count <= error_count + 32'd1;
            RSP_TVALID <= 1'b1;
            RSP_TDATA  <= {5'b0, 1'b1, M_AXI_RRESP, M_AXI_RDATA};
          end
        end
        RSP: begin
          if (RSP_TREADY) begin
            state      <= IDLE;
            RSP_TVALID <= 1'b0;
            REQ_TREADY <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
